// File: rtl/pipe_pkg.sv
// Shared encodings and helpers for the pipeline memory-access stage.
package pipe_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Reserved size counts as misaligned so it never reaches the bus.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = addr_lo[0];
            SZ_WORD: r = |addr_lo;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store enables/replicated data and load lane extract with extension.
module mem_align
    import pipe_pkg::*;
(
    input  logic [1:0]      i_size,
    input  logic [1:0]      i_addr_lo,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_st_data,
    input  logic [XLEN-1:0] i_ld_word,
    output logic [BE_W-1:0] o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_st_data[7:0]}};
            end
            SZ_HALF: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_ld_byte = i_ld_word[7:0];
        case (i_addr_lo)
            2'd1:    w_ld_byte = i_ld_word[15:8];
            2'd2:    w_ld_byte = i_ld_word[23:16];
            2'd3:    w_ld_byte = i_ld_word[31:24];
            default: w_ld_byte = i_ld_word[7:0];
        endcase
        w_ld_half = i_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];

        o_ld_data = i_ld_word;
        case (i_size)
            SZ_BYTE: o_ld_data = i_unsigned ? {24'b0, w_ld_byte} : {{24{w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: o_ld_data = i_unsigned ? {16'b0, w_ld_half} : {{16{w_ld_half[15]}}, w_ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_mem.sv
// Memory-access pipeline stage: issues data-memory transactions over req/ack,
// stalls upstream while one is outstanding, and registers the MEM/WB fields.
module pipe_mem
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [4:0]      in_rd_waddr,
    input  logic            in_rd_wena,
    input  logic            in_rd_sel,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_rt_data,
    input  logic            in_mem_ren,
    input  logic            in_mem_wen,
    input  logic [1:0]      in_mem_size,
    input  logic            in_mem_unsigned,
    output logic            out_stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [BE_W-1:0] dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [4:0]      out_rd_waddr,
    output logic            out_rd_wena,
    output logic            out_rd_sel,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_dmem_data,
    output logic            out_addr_err
);

    mem_state_t r_state;
    mem_state_t w_next;

    logic            w_mem_op;
    logic            w_misal;
    logic            w_issue;
    logic            w_err;
    logic [BE_W-1:0] w_st_be;
    logic [XLEN-1:0] w_st_wdata;
    logic [XLEN-1:0] w_ld_data;
    logic [XLEN-1:0] w_st_ldata_unused;
    logic [BE_W-1:0] w_ld_be_unused;
    logic [XLEN-1:0] w_ld_wdata_unused;

    // Instruction captured at issue, retired into the output register on ack.
    logic [4:0]      r_p_waddr;
    logic            r_p_wena;
    logic            r_p_sel;
    logic            r_p_load;
    logic            r_p_unsigned;
    logic [1:0]      r_p_size;
    logic [XLEN-1:0] r_p_alu;

    assign w_mem_op = in_valid & (in_mem_ren | in_mem_wen);
    assign w_misal  = is_misaligned(in_mem_size, in_alu_result[1:0]);
    assign w_issue  = (r_state == IDLE) & w_mem_op & ~w_misal;
    assign w_err    = (r_state == IDLE) & w_mem_op & w_misal;

    mem_align u_store_align (
        .i_size     (in_mem_size),
        .i_addr_lo  (in_alu_result[1:0]),
        .i_unsigned (in_mem_unsigned),
        .i_st_data  (in_rt_data),
        .i_ld_word  (dmem_rdata),
        .o_be       (w_st_be),
        .o_wdata    (w_st_wdata),
        .o_ld_data  (w_st_ldata_unused)
    );

    mem_align u_load_align (
        .i_size     (r_p_size),
        .i_addr_lo  (r_p_alu[1:0]),
        .i_unsigned (r_p_unsigned),
        .i_st_data  ('0),
        .i_ld_word  (dmem_rdata),
        .o_be       (w_ld_be_unused),
        .o_wdata    (w_ld_wdata_unused),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Stall drops in the ack cycle so upstream advances on the completing edge.
    always_comb begin
        w_next    = r_state;
        out_stall = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_next    = BUSY;
                    out_stall = 1'b1;
                end
            end
            BUSY: begin
                if (dmem_ack) w_next    = IDLE;
                else          out_stall = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_be        <= '0;
            dmem_wdata     <= '0;
            out_rd_waddr   <= '0;
            out_rd_wena    <= 1'b0;
            out_rd_sel     <= 1'b0;
            out_alu_result <= '0;
            out_dmem_data  <= '0;
            out_addr_err   <= 1'b0;
            r_p_waddr      <= '0;
            r_p_wena       <= 1'b0;
            r_p_sel        <= 1'b0;
            r_p_load       <= 1'b0;
            r_p_unsigned   <= 1'b0;
            r_p_size       <= '0;
            r_p_alu        <= '0;
        end else if (r_state == IDLE) begin
            out_addr_err <= w_err;
            if (w_issue) begin
                dmem_req     <= 1'b1;
                dmem_we      <= in_mem_wen;
                dmem_addr    <= {in_alu_result[XLEN-1:2], 2'b00};
                dmem_be      <= w_st_be;
                dmem_wdata   <= w_st_wdata;
                r_p_waddr    <= in_rd_waddr;
                r_p_wena     <= in_rd_wena & in_mem_ren;
                r_p_sel      <= in_rd_sel;
                r_p_load     <= in_mem_ren;
                r_p_unsigned <= in_mem_unsigned;
                r_p_size     <= in_mem_size;
                r_p_alu      <= in_alu_result;
                out_rd_wena  <= 1'b0;
            end else begin
                out_rd_waddr   <= in_rd_waddr;
                out_rd_sel     <= in_rd_sel;
                out_alu_result <= in_alu_result;
                out_rd_wena    <= in_valid & in_rd_wena & ~w_err;
            end
        end else if (dmem_ack) begin
            dmem_req       <= 1'b0;
            out_rd_waddr   <= r_p_waddr;
            out_rd_wena    <= r_p_wena;
            out_rd_sel     <= r_p_sel;
            out_alu_result <= r_p_alu;
            if (r_p_load) out_dmem_data <= w_ld_data;
        end
    end

endmodule

// File: tb/tb_pipe_mem.sv
// Randomized bench for pipe_mem against a transaction-level model of the stage.
module tb_pipe_mem;

    typedef struct packed {
        logic        valid;
        logic [4:0]  waddr;
        logic        wena;
        logic        sel;
        logic [31:0] alu;
        logic [31:0] rt;
        logic        ren;
        logic        wen;
        logic [1:0]  size;
        logic        uns;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_rd_wena, in_rd_sel, in_mem_ren, in_mem_wen, in_mem_unsigned;
    logic [4:0]  in_rd_waddr;
    logic [31:0] in_alu_result, in_rt_data;
    logic [1:0]  in_mem_size;
    logic        out_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [4:0]  out_rd_waddr;
    logic        out_rd_wena, out_rd_sel, out_addr_err;
    logic [31:0] out_alu_result, out_dmem_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_mem dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_rd_waddr     (in_rd_waddr),
        .in_rd_wena      (in_rd_wena),
        .in_rd_sel       (in_rd_sel),
        .in_alu_result   (in_alu_result),
        .in_rt_data      (in_rt_data),
        .in_mem_ren      (in_mem_ren),
        .in_mem_wen      (in_mem_wen),
        .in_mem_size     (in_mem_size),
        .in_mem_unsigned (in_mem_unsigned),
        .out_stall       (out_stall),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .out_rd_waddr    (out_rd_waddr),
        .out_rd_wena     (out_rd_wena),
        .out_rd_sel      (out_rd_sel),
        .out_alu_result  (out_alu_result),
        .out_dmem_data   (out_dmem_data),
        .out_addr_err    (out_addr_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference rules in plain arithmetic.
    function automatic bit m_misal(input logic [1:0] size, input logic [31:0] a);
        return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] a);
        int lane;
        lane = int'(a % 4);
        if (size == 2'd0) return 4'(1 << lane);
        if (size == 2'd1) return (lane >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] rt);
        if (size == 2'd0) return (rt & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (rt & 32'hFFFF) * 32'h0001_0001;
        return rt;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * (a % 4));
        if (size == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    task automatic drive(input op_t op);
        in_valid        = op.valid;
        in_rd_waddr     = op.waddr;
        in_rd_wena      = op.wena;
        in_rd_sel       = op.sel;
        in_alu_result   = op.alu;
        in_rt_data      = op.rt;
        in_mem_ren      = op.ren;
        in_mem_wen      = op.wen;
        in_mem_size     = op.size;
        in_mem_unsigned = op.uns;
    endtask

    // Entered and left at posedge+1; k is the ack cycle counted from the first req cycle.
    task automatic run_op(input op_t op, input int k, input logic [31:0] rdata, input bit stray);
        bit mem, mis;
        mem = op.valid && (op.ren || op.wen);
        mis = mem && m_misal(op.size, op.alu);
        drive(op);
        #1;
        if (!mem || mis) begin
            check("stall_idle", 32'(out_stall), 32'd0);
            if (stray) begin
                dmem_ack   = 1'b1;
                dmem_rdata = $urandom;
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            check("req_idle", 32'(dmem_req), 32'd0);
            check("addr_err", 32'(out_addr_err), 32'(mis));
            check("wena_idle", 32'(out_rd_wena), mem ? 32'd0 : 32'(op.valid & op.wena));
            if (!mem) begin
                check("waddr_idle", 32'(out_rd_waddr), 32'(op.waddr));
                check("sel_idle", 32'(out_rd_sel), 32'(op.sel));
                check("alu_idle", out_alu_result, op.alu);
            end
        end else begin
            check("stall_issue", 32'(out_stall), 32'd1);
            check("req_pre", 32'(dmem_req), 32'd0);
            @(posedge clk); #1;
            check("req_up", 32'(dmem_req), 32'd1);
            check("dmem_addr", dmem_addr, op.alu & 32'hFFFF_FFFC);
            check("dmem_we", 32'(dmem_we), 32'(op.wen));
            check("dmem_be", 32'(dmem_be), 32'(m_be(op.size, op.alu)));
            if (op.wen) check("dmem_wdata", dmem_wdata, m_wdata(op.size, op.rt));
            check("bubble_wena", 32'(out_rd_wena), 32'd0);
            for (int j = 1; j < k; j++) begin
                check("stall_wait", 32'(out_stall), 32'd1);
                @(posedge clk); #1;
                check("req_hold", 32'(dmem_req), 32'd1);
                check("addr_hold", dmem_addr, op.alu & 32'hFFFF_FFFC);
            end
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
            #1;
            check("stall_ack", 32'(out_stall), 32'd0);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            check("req_drop", 32'(dmem_req), 32'd0);
            check("waddr_done", 32'(out_rd_waddr), 32'(op.waddr));
            check("sel_done", 32'(out_rd_sel), 32'(op.sel));
            check("alu_done", out_alu_result, op.alu);
            check("wena_done", 32'(out_rd_wena), 32'(op.ren & op.wena));
            check("err_done", 32'(out_addr_err), 32'd0);
            if (op.ren) check("load_data", out_dmem_data, m_load(op.size, op.uns, op.alu, rdata));
        end
    endtask

    function automatic op_t mk(input logic [31:0] alu, input logic ren, input logic wen,
                               input logic [1:0] size, input logic uns, input logic [31:0] rt,
                               input logic [4:0] rd, input logic sel);
        op_t o;
        o.valid = 1'b1; o.waddr = rd; o.wena = 1'b1; o.sel = sel; o.alu = alu;
        o.rt = rt; o.ren = ren; o.wen = wen; o.size = size; o.uns = uns;
        return o;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t op;
        op_t idle_op;
        idle_op  = '0;
        drive(idle_op);
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(out_stall), 32'd0);
        check("rst_wena", 32'(out_rd_wena), 32'd0);
        check("rst_alu", out_alu_result, 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_err", 32'(out_addr_err), 32'd0);
        rst_n = 1'b1;

        run_op(mk(32'h1234, 0, 0, 2'd2, 0, 0, 5'd5, 1), 1, 0, 0);
        run_op(mk(32'h103, 1, 0, 2'd0, 0, 0, 5'd7, 0), 2, 32'h80FF_0000, 0);
        run_op(mk(32'h202, 0, 1, 2'd1, 0, 32'hAAAA_BEEF, 5'd9, 0), 1, 0, 0);
        run_op(mk(32'h301, 1, 0, 2'd2, 0, 0, 5'd3, 0), 1, 0, 0);
        run_op(mk(32'h2, 1, 0, 2'd0, 1, 0, 5'd10, 0), 1, 32'h12AB_3456, 0);
        run_op(mk(32'h8, 1, 0, 2'd2, 0, 0, 5'd11, 0), 1, 32'hDEAD_BEEF, 0);

        // Abandon an outstanding load with reset, then confirm normal operation.
        drive(mk(32'hABC4, 1, 0, 2'd2, 0, 32'h5555_0000, 5'd12, 1));
        @(posedge clk); #1;
        check("busy_req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        drive(idle_op);
        #1;
        check("rstb_req", 32'(dmem_req), 32'd0);
        check("rstb_stall", 32'(out_stall), 32'd0);
        check("rstb_addr", dmem_addr, 32'd0);
        check("rstb_we", 32'(dmem_we), 32'd0);
        check("rstb_be", 32'(dmem_be), 32'd0);
        check("rstb_wdata", dmem_wdata, 32'd0);
        check("rstb_alu", out_alu_result, 32'd0);
        check("rstb_dmem", out_dmem_data, 32'd0);
        check("rstb_waddr", 32'(out_rd_waddr), 32'd0);
        check("rstb_sel", 32'(out_rd_sel), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(mk(32'h46, 1, 0, 2'd1, 0, 0, 5'd13, 0), 3, 32'h8001_7FFF, 0);

        for (int n = 0; n < 400; n++) begin
            int kind;
            op.valid = ($urandom_range(0, 9) != 0);
            op.waddr = 5'($urandom);
            op.wena  = 1'($urandom);
            op.sel   = 1'($urandom);
            op.rt    = $urandom;
            op.uns   = 1'($urandom);
            kind     = int'($urandom_range(0, 2));
            op.ren   = (kind == 1);
            op.wen   = (kind == 2);
            op.size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            op.alu   = $urandom;
            if ($urandom_range(0, 4) < 3) begin
                if (op.size == 2'd2)      op.alu = op.alu & 32'hFFFF_FFFC;
                else if (op.size == 2'd1) op.alu = op.alu & 32'hFFFF_FFFE;
            end
            run_op(op, int'($urandom_range(1, 4)), $urandom, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
